// File: rtl/luma2rgb_serializer.sv
// luma2rgb_serializer: BT.601 limited-range luma to full-range gray, serialized
// as three tagged bytes (R, G, B) on a valid/ready output stream.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   data_in/valid_in       luma sample input stream
//   ready_in               input FIFO not full (from registered count)
//   data_out/color_out     colour byte and one-hot tag (001 R, 010 G, 100 B)
//   valid_out/ready_out    output stream handshake
module luma2rgb_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter bit EXPAND     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [7:0] data_out,
    output logic [2:0] color_out,
    output logic       valid_out,
    input  logic       ready_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RED, GREEN, BLUE} state_t;

    state_t state, next_state;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    pix;
    logic [7:0]    g_in;
    logic          push, pop, fire, empty;

    // Signed arithmetic; the >>> 8 floors, matching the rounding intent
    // of the +128 bias. Inputs below 16 are forced to black.
    function automatic logic [7:0] expand(input logic [7:0] y);
        logic signed [19:0] t;
        t = signed'({12'd0, y}) - 20'sd16;
        t = t * 20'sd298;
        t = t + 20'sd128;
        t = t >>> 8;
        if (y < 8'd16)
            return 8'd0;
        else if (t > 20'sd255)
            return 8'd255;
        else
            return t[7:0];
    endfunction

    assign ready_in = (count != FULL);
    assign empty    = (count == '0);
    assign push     = valid_in && ready_in;
    assign fire     = valid_out && ready_out;
    assign g_in     = EXPAND ? expand(mem[rd_ptr]) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    // Pointers wrap naturally: depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pix <= 8'd0;
        else if (pop)
            pix <= g_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // BLUE pops straight into RED so back-to-back pixels have no bubble.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = RED;
                end
            end
            RED: begin
                if (fire)
                    next_state = GREEN;
            end
            GREEN: begin
                if (fire)
                    next_state = BLUE;
            end
            BLUE: begin
                if (fire) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = RED;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        valid_out = 1'b0;
        data_out  = 8'd0;
        color_out = 3'b001;
        unique case (state)
            IDLE: begin
                valid_out = 1'b0;
            end
            RED: begin
                valid_out = 1'b1;
                data_out  = pix;
                color_out = 3'b001;
            end
            GREEN: begin
                valid_out = 1'b1;
                data_out  = pix;
                color_out = 3'b010;
            end
            BLUE: begin
                valid_out = 1'b1;
                data_out  = pix;
                color_out = 3'b100;
            end
        endcase
    end

endmodule

// File: tb/tb_luma2rgb_serializer.sv
// tb_luma2rgb_serializer: randomized and directed checks of the luma-to-RGB
// serializer against a queue-based byte model.
module tb_luma2rgb_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic [7:0] data_out;
    logic [2:0] color_out;
    logic       valid_out;
    logic       ready_out = 1'b0;

    logic [7:0] d1_in = 8'd0;
    logic       v1_in = 1'b0;
    logic       r1_in;
    logic [7:0] d1_out;
    logic [2:0] c1_out;
    logic       v1_out;
    logic       r1_out = 1'b1;

    luma2rgb_serializer #(.FIFO_DEPTH(2), .EXPAND(1'b1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (data_out),
        .color_out(color_out),
        .valid_out(valid_out),
        .ready_out(ready_out)
    );

    luma2rgb_serializer #(.FIFO_DEPTH(2), .EXPAND(1'b0)) u_raw (
        .clk      (clk),
        .rst      (rst),
        .data_in  (d1_in),
        .valid_in (v1_in),
        .ready_in (r1_in),
        .data_out (d1_out),
        .color_out(c1_out),
        .valid_out(v1_out),
        .ready_out(r1_out)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    bit          acc;
    bit          hold = 1'b0;
    logic [10:0] held;
    int          run = 0;
    int          last_run = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full-range gray from limited-range luma, plain integer arithmetic.
    function automatic logic [7:0] gray(input int y);
        int v;
        if (y < 16)
            return 8'd0;
        v = ((y - 16) * 298 + 128) / 256;
        if (v > 255)
            v = 255;
        return v[7:0];
    endfunction

    task automatic observe();
        logic [7:0] g;
        acc = valid_in && ready_in;
        if (acc) begin
            g = gray(int'(data_in));
            exp_q.push_back({3'b001, g});
            exp_q.push_back({3'b010, g});
            exp_q.push_back({3'b100, g});
        end
        if (hold)
            chk("hold", {21'd0, color_out, data_out}, {21'd0, held});
        if (valid_out && ready_out) begin
            if (exp_q.size() == 0)
                chk("extra_byte", 32'd1, 32'd0);
            else
                chk("byte", {21'd0, color_out, data_out},
                    {21'd0, exp_q.pop_front()});
            run++;
        end else if (!valid_out) begin
            if (run != 0)
                last_run = run;
            run = 0;
        end
        hold = valid_out && !ready_out;
        held = {color_out, data_out};
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        ready_out = r;
        #1;
        observe();
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        do begin
            step(1'b0, 8'd0, 1'b1);
            k++;
        end while ((exp_q.size() != 0 || valid_out) && k < lim);
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic push_one(input logic [7:0] y, input bit r);
        int k;
        k = 0;
        do begin
            step(1'b1, y, r);
            k++;
        end while (!acc && k < 50);
        if (!acc)
            chk("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] burst [5];
        logic [2:0] tags [3];
        int nacc, sent, k, nb;
        burst = '{8'd235, 8'd128, 8'd100, 8'd255, 8'd10};
        tags  = '{3'b001, 3'b010, 3'b100};

        #12;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_color", color_out, 3'b001);
        chk("rst_data", data_out, 8'd0);
        chk("rst_ready", ready_in, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 8'd16, 1'b1);
        chk("lat_acc", acc, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("lat_edge_n", valid_out, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        chk("lat_edge_n1", valid_out, 1'b1);
        chk("lat_tag", color_out, 3'b001);
        chk("lat_data", data_out, 8'd0);
        drain(20);

        run = 0;
        last_run = 0;
        for (int i = 0; i < 5; i++)
            push_one(burst[i], 1'b1);
        drain(40);
        chk("burst_run", last_run, 32'd15);

        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            if (acc)
                nacc++;
        end
        chk("stall_accepts", nacc, 32'd3);
        chk("stall_ready_in", ready_in, 1'b0);
        chk("stall_valid", valid_out, 1'b1);
        drain(100);

        sent = 0;
        k = 0;
        while (sent < 1000 && k < 20000) begin
            step($urandom_range(3) != 0, 8'($urandom),
                 $urandom_range(2) != 0);
            if (acc)
                sent++;
            k++;
        end
        chk("rand_sent", sent, 32'd1000);
        drain(200);

        push_one(8'd200, 1'b0);
        push_one(8'd50, 1'b0);
        push_one(8'd90, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        @(negedge clk);
        ready_out = 1'b0;
        #1;
        chk("pre_rst_green", color_out, 3'b010);
        chk("pre_rst_full", ready_in, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", valid_out, 1'b0);
        chk("arst_color", color_out, 3'b001);
        chk("arst_ready", ready_in, 1'b1);
        chk("arst_data", data_out, 8'd0);
        exp_q.delete();
        hold = 1'b0;
        run = 0;
        @(negedge clk);
        rst = 1'b0;
        push_one(8'd128, 1'b1);
        drain(20);

        @(negedge clk);
        d1_in = 8'h5A;
        v1_in = 1'b1;
        #1;
        chk("raw_ready", r1_in, 1'b1);
        @(negedge clk);
        v1_in = 1'b0;
        nb = 0;
        k = 0;
        while (nb < 3 && k < 20) begin
            @(negedge clk);
            #1;
            if (v1_out) begin
                chk("raw_data", d1_out, 8'h5A);
                chk("raw_tag", c1_out, tags[nb]);
                nb++;
            end
            k++;
        end
        chk("raw_count", nb, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/luma2rgb_serializer.md
Name: luma2rgb_serializer

Overview:
- Inverse companion to the RGB-to-luma converter.
- Accepts 8-bit BT.601 limited-range luma samples on a valid/ready input stream.
- Expands each sample to full-range gray and emits it as three serial bytes (R, G, B) on a valid/ready output stream, in the same byte order and one-hot colour encoding the converter consumes.
- Feeds the display/readback path and loopback tests of the luma pipeline.

Parameters:
- FIFO_DEPTH, 2, input sample FIFO entries; power of two, ≥2.
- EXPAND, 1, 1 = limited-to-full-range expansion; 0 = replicate raw luma unchanged.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- data_in  input  8  luma sample.
- valid_in  input  1  data_in valid.
- ready_in  output  1  block can accept a sample (FIFO not full).
- data_out  output  8  colour byte.
- color_out  output  3  one-hot tag of data_out: 001 = R, 010 = G, 100 = B.
- valid_out  output  1  data_out/color_out valid.
- ready_out  input  1  downstream accepts the byte.

Behaviour:
- Reset values: rst is asynchronous, active-high; clock is clk.
  - data_out = 0, color_out = 001, valid_out = 0.
  - ready_in = 1, FIFO empty, FSM = IDLE.
- Input handshake:
  - Sample is written when valid_in && ready_in at a rising edge.
  - ready_in = (count != FIFO_DEPTH), driven from the registered count; no combinational path from ready_out.
- Conversion, applied at FIFO pop:
  - EXPAND = 1: g = ((Y − 16) × 298 + 128) >> 8, computed signed with ≥18 bits; clamp to 0 if Y < 16 and to 255 if the result > 255.
  - EXPAND = 0: g = Y.
- FSM states IDLE, RED, GREEN, BLUE. A byte "fires" when valid_out && ready_out.
  - IDLE: valid_out = 0. If FIFO non-empty, pop, load g into the pixel register, go to RED.
  - RED: data_out = g, color_out = 001. On fire, go to GREEN.
  - GREEN: data_out = g, color_out = 010. On fire, go to BLUE.
  - BLUE: data_out = g, color_out = 100. On fire: if FIFO non-empty, pop and go to RED in the same edge (no bubble); else go to IDLE.
  - No fire: hold state; data_out and color_out stay stable while valid_out = 1.
- Latency: a sample accepted at edge N into an empty block has its R byte valid after edge N+1.
- Throughput: one pixel per 3 cycles with ready_out held high.
- Simultaneous push and pop in the same edge: count is unchanged, data is preserved in order.
- Full FIFO: ready_in = 0; valid_in is ignored and no sample is lost or overwritten.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset mid-pixel: the partial pixel and all FIFO contents are discarded; outputs return to reset values immediately.
- valid_out never depends combinationally on ready_out.

Test Plan:
- Reset release, then push Y = 16, ready_out = 1 → three bytes 0x00 with color_out 001, 010, 100 on consecutive cycles; first byte valid after edge N+1.
- Push Y = 235, 128, 100, 255, 10 back-to-back (EXPAND = 1), ready_out = 1 → gray values 255, 130, 98, 255 (clamped), 0 (clamped); 15 consecutive valid bytes, no bubbles.
- ready_out = 0 while valid_in held high with a stream → FIFO fills after FIFO_DEPTH samples plus 1 in the pixel register, ready_in drops; data_out/color_out stable; release ready_out → all samples emitted in order, none lost.
- Random ready_out toggling, 1000 random samples → output equals the golden model of three bytes per sample, tags cycle 001 → 010 → 100 strictly.
- Assert rst while in the GREEN state with the FIFO holding 2 samples → valid_out = 0, color_out = 001, ready_in = 1 asynchronously; after release, a new sample Y = 128 emits 130 ×3 with no stale data.
- EXPAND = 0, push Y = 0x5A → three bytes 0x5A tagged R, G, B.
